burst_counter_mc: RTL and testbench

BURST_COUNTER_MC -- requirements
Module: burst_counter_mc

---
 rtl/burst_cnt_pkg.sv | 12 +
 rtl/burst_counter_ch.sv | 88 ++++++++
 rtl/burst_counter_mc.sv | 42 ++++
 tb/tb_burst_counter_mc.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_cnt_pkg.sv
// Shared types and default sizing for the multi-channel burst counter.
package burst_cnt_pkg;

  localparam int unsigned CNT_W_DEF  = 4;
  localparam int unsigned NUM_CH_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/burst_counter_ch.sv
// One independent burst channel: latches a burst length on start and
// steps a beat index, with pause, cancel and optional auto-repeat.
module burst_counter_ch
  import burst_cnt_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             wrap_mode,
  input  logic             beat,
  input  logic             stop,
  input  logic             abort,
  output logic [CNT_W-1:0] count,
  output logic             last,
  output logic             busy,
  output logic             done
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             last_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; abort overrides every other request
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    done_d  = 1'b0;
    last_c  = (state_q == RUN) && (count_q == len_q);

    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          count_d = '0;
          if (start) begin
            len_d   = len;
            state_d = RUN;
          end
        end
        RUN: begin
          if (beat && !stop) begin
            if (last_c) begin
              // Final beat: wrap_mode is sampled here, not at start
              count_d = '0;
              done_d  = 1'b1;
              state_d = wrap_mode ? RUN : IDLE;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign last  = last_c;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule

// File: rtl/burst_counter_mc.sv
// Multi-channel burst counter: NUM_CH independent channels packed onto
// flat vector ports; the top holds wiring only.
module burst_counter_mc
  import burst_cnt_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned NUM_CH = NUM_CH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH*CNT_W-1:0] len,
  input  logic [NUM_CH-1:0]       wrap_mode,
  input  logic [NUM_CH-1:0]       beat,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       abort,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       last,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    burst_counter_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .start     (start[gi]),
      .len       (len[gi*CNT_W +: CNT_W]),
      .wrap_mode (wrap_mode[gi]),
      .beat      (beat[gi]),
      .stop      (stop[gi]),
      .abort     (abort[gi]),
      .count     (count[gi*CNT_W +: CNT_W]),
      .last      (last[gi]),
      .busy      (busy[gi]),
      .done      (done[gi])
    );
  end

endmodule

// File: tb/tb_burst_counter_mc.sv
// Scoreboard bench for burst_counter_mc: directed scenarios plus random
// traffic, checked against a beat-index reference model.
module tb_burst_counter_mc;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned NUM_CH = 2;
  localparam int          MAXLEN = (1 << CNT_W) - 1;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH*CNT_W-1:0] len;
  logic [NUM_CH-1:0]       wrap_mode;
  logic [NUM_CH-1:0]       beat;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       abort;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       last;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;

  typedef struct packed {
    logic [NUM_CH*CNT_W-1:0] count;
    logic [NUM_CH-1:0]       last;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: per channel, whether a burst is active, which beat
  // it is on, the latched last-beat index and a pending done pulse.
  bit m_act  [NUM_CH];
  int m_idx  [NUM_CH];
  int m_len  [NUM_CH];
  bit m_done [NUM_CH];

  burst_counter_mc #(
    .CNT_W  (CNT_W),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .wrap_mode (wrap_mode),
    .beat      (beat),
    .stop      (stop),
    .abort     (abort),
    .count     (count),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_act[i]  = 1'b0;
      m_idx[i]  = 0;
      m_len[i]  = 0;
      m_done[i] = 1'b0;
    end
  endfunction

  // One clock edge of the behavioural rules, using inputs seen at the edge.
  function automatic void model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      bit fin;
      fin = m_act[i] && beat[i] && !stop[i] && (m_idx[i] == m_len[i]);
      m_done[i] = fin && !abort[i];
      if (abort[i]) begin
        m_act[i] = 1'b0;
        m_idx[i] = 0;
      end else if (!m_act[i]) begin
        if (start[i]) begin
          m_act[i] = 1'b1;
          m_idx[i] = 0;
          m_len[i] = int'(len[i*CNT_W +: CNT_W]);
        end
      end else if (fin) begin
        m_idx[i] = 0;
        m_act[i] = wrap_mode[i];
      end else if (beat[i] && !stop[i]) begin
        m_idx[i] = m_idx[i] + 1;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      e.count[i*CNT_W +: CNT_W] = CNT_W'(m_act[i] ? m_idx[i] : 0);
      e.last[i] = m_act[i] && (m_idx[i] == m_len[i]);
      e.busy[i] = m_act[i];
      e.done[i] = m_done[i];
    end
    return e;
  endfunction

  // Stimulus side: advance the model at each edge, then queue the
  // expected outputs once any mid-cycle reset has been applied.
  always @(posedge clk) begin
    model_edge();
    #2;
    exp_q.push_back(model_out());
  end

  // Monitor: compare whatever the DUT presents mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (count !== e.count || last !== e.last || busy !== e.busy || done !== e.done) begin
        n_fail++;
        $display("FAIL outputs t=%0t count=%h/%h last=%b/%b busy=%b/%b done=%b/%b (actual/required)",
                 $time, count, e.count, last, e.last, busy, e.busy, done, e.done);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = '0; beat = '0; stop = '0; abort = '0; wrap_mode = '0;
  endtask

  task automatic set_len(input int ch, input int v);
    len[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic direct_check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin
    rst = 1'b1;
    len = '0;
    idle_inputs();
    model_reset();
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // Single 4-beat burst, beat held
    start[0] = 1'b1; set_len(0, 3); beat[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    repeat (6) cyc();

    // Pause at count=1 for three cycles
    start[0] = 1'b1; set_len(0, 2); beat[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    cyc();
    stop[0] = 1'b1;
    repeat (3) cyc();
    stop[0] = 1'b0;
    repeat (4) cyc();
    idle_inputs();

    // Wrap mode on ch1, then cancel
    start[1] = 1'b1; set_len(1, 1); wrap_mode[1] = 1'b1; beat[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    repeat (6) cyc();
    abort[1] = 1'b1;
    cyc();
    idle_inputs();
    cyc();

    // Abort mid-burst beats start and beat
    start[0] = 1'b1; set_len(0, 15); beat[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    repeat (7) cyc();
    abort[0] = 1'b1; start[0] = 1'b1;
    cyc();
    idle_inputs();
    repeat (2) cyc();

    // Both channels started together; restart on busy ch1 ignored
    start = 2'b11; set_len(0, 0); set_len(1, 5); beat = 2'b11;
    cyc();
    start = 2'b10; set_len(1, 2);
    cyc();
    start = '0;
    repeat (8) cyc();
    idle_inputs();

    // Full-length burst on ch1
    start[1] = 1'b1; set_len(1, MAXLEN); beat[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    repeat (18) cyc();
    idle_inputs();

    // Asynchronous reset mid-burst
    start[0] = 1'b1; set_len(0, 5); beat[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    model_reset();
    #1;
    direct_check("async_rst_count0", 32'(count[CNT_W-1:0]), 32'd0);
    direct_check("async_rst_busy", 32'(busy), 32'd0);
    direct_check("async_rst_done", 32'(done), 32'd0);
    cyc();
    rst = 1'b0;
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    repeat (8) cyc();
    idle_inputs();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        start[i]     = ($urandom_range(0, 3) == 0);
        set_len(i, int'($urandom_range(0, MAXLEN)));
        wrap_mode[i] = $urandom_range(0, 1) == 1;
        beat[i]      = ($urandom_range(0, 9) < 7);
        stop[i]      = ($urandom_range(0, 9) < 2);
        abort[i]     = ($urandom_range(0, 39) == 0);
      end
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      cyc();
    end

    rst = 1'b0;
    idle_inputs();
    repeat (4) cyc();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
